// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter: default widths, the r0 address
// and the write request record used by both requesters and the registered RF port.
package wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 5;

    localparam logic [WB_AW-1:0] R0 = '0;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] ws;
        logic [WB_DW-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// Counts cycles a pending B result has lost arbitration; flags a forced grant at STARVE_LIM-1.
// Latency: o_force is combinational from the counter register; no backpressure of its own.
module wb_starve_ctr #(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_b_valid,
    input  logic i_b_hs,
    output logic o_force
);

    localparam int SW = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
    localparam logic [SW-1:0] LIM_M1 = SW'(STARVE_LIM - 1);

    logic [SW-1:0] r_cnt;
    logic          w_at_lim;

    assign w_at_lim = (r_cnt == LIM_M1);
    assign o_force  = w_at_lim;

    // Saturates rather than wraps so a post-stall deferral keeps the force pending.
    always_ff @(posedge clk) begin
        if (rst || !i_b_valid || i_b_hs) begin
            r_cnt <= '0;
        end else if (!w_at_lim) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single RF write port between the pipeline writeback stage and a valid/ready
// multi-cycle unit; grant is combinational, the RF port is registered (1 cycle latency).
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DW         = WB_DW,
    parameter int AW         = WB_AW,
    parameter int STARVE_LIM = 4,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] P_WD,
    input  logic [AW-1:0] P_WS,
    input  logic          P_WE,
    output logic          STALL,
    input  logic          B_VALID,
    input  logic [DW-1:0] B_WD,
    input  logic [AW-1:0] B_WS,
    output logic          B_READY,
    output logic          RF_WE,
    output logic [AW-1:0] RF_WS,
    output logic [DW-1:0] RF_WD,
    output logic [CW-1:0] STALL_CNT
);

    wb_req_t       w_p;
    wb_req_t       w_b;
    wb_req_t       r_rf;
    logic          w_p_eff;
    logic          w_conflict;
    logic          w_force;
    logic          w_grant_b;
    logic          w_stall;
    logic          r_stall_q;
    logic [CW-1:0] r_stall_cnt;

    assign w_p = '{we: P_WE, ws: P_WS, wd: P_WD};
    assign w_b = '{we: B_VALID, ws: B_WS, wd: B_WD};

    assign w_p_eff    = w_p.we && (w_p.ws != R0);
    assign w_conflict = w_p_eff && w_b.we && (w_p.ws == w_b.ws);

    // On a shared destination B is the older instruction, so it must write first.
    assign w_grant_b = !rst && w_b.we && !r_stall_q &&
                       (!w_p_eff || w_conflict || w_force);
    assign w_stall   = w_grant_b && w_p_eff;

    assign STALL   = w_stall;
    assign B_READY = w_grant_b;

    wb_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_b_valid (w_b.we),
        .i_b_hs    (w_grant_b),
        .o_force   (w_force)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf        <= '0;
            r_stall_q   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_stall_q <= w_stall;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            // A B result to r0 still completes its handshake but is dropped here.
            if (w_grant_b) begin
                r_rf <= '{we: (w_b.ws != R0), ws: w_b.ws, wd: w_b.wd};
            end else if (w_p_eff) begin
                r_rf <= w_p;
            end else begin
                r_rf.we <= 1'b0;
            end
        end
    end

    assign RF_WE     = r_rf.we;
    assign RF_WS     = r_rf.ws;
    assign RF_WD     = r_rf.wd;
    assign STALL_CNT = r_stall_cnt;

endmodule
